e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit, directly downstream of the D/E pipeline register.
- Consumes the E-stage operands RD1E and RD2E plus a decoded MDU opcode, and owns the architectural HI/LO registers.
- Emulates multi-cycle latency with a countdown counter.
- Exports busy so the hazard unit can stall mult/div/mfhi/mflo instructions sitting in D.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; reset=0 clears the block immediately.
- start  input  1  E-stage instruction is an MDU op; qualified by the op field.
- mdu_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 are no-ops.
- rs_val  input  32  forwarded RD1E (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  forwarded RD2E (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending_hi=0, pending_lo=0. Takes effect without a clock edge and overrides everything, including an operation in flight; the in-flight result is discarded.
- States: IDLE (busy=0), RUN (busy=1). Counter is 4 bits.
- IDLE, start=1, op mult/multu/div/divu at a clk edge:
  - Capture the full result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from that edge on.
- IDLE, start=1, op mthi/mtlo: hi (or lo) <= rs_val at that edge. Single cycle, busy stays 0, pending registers untouched.
- IDLE, start=1, op 110/111: no effect.
- RUN, each edge: counter decrements.
  - At the edge where counter==1: hi<=pending_hi, lo<=pending_lo, counter=0, state IDLE, busy=0.
  - busy is therefore high for exactly N clock cycles after the start edge.
  - New hi/lo are visible in the cycle following the N-th edge (start edge included as edge 0).
- start while busy=1: ignored entirely, including mthi/mtlo. The hazard unit guarantees this never happens legitimately; the bench checks the ignore rule.
- Result rules:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64; same split.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - Divisor zero (div/divu): full DIV_CYCLES busy period still runs; hi/lo keep their old values at completion.
- hi/lo outputs are registers with no combinational bypass from pending or rs_val.
- Operands are sampled only on the start edge; later changes on rs_val/rt_val have no effect.

Test Plan:
- Reset released, no start -> hi=0, lo=0, busy=0. Assert reset=0 between clock edges -> outputs clear without waiting for an edge.
- mult rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=0 after mthi 0x1234, mtlo 0x5678 -> busy 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
- mult 6x7 started; on cycle 2 of busy pulse start with mtlo rs=0xAAAA and with a second mult -> both ignored; final hi=0, lo=42; busy falls after 5 cycles.
- div started; reset=0 asserted on busy cycle 4 -> busy=0, hi=lo=0 immediately. Release reset, issue mult 3x3 -> lo=9 after 5 cycles.
- mthi rs=0xDEADBEEF with start=1 -> hi=0xDEADBEEF at the next edge, busy never asserts. Back-to-back mtlo 1, then mult 2x2 on the following cycle -> lo=1 then lo=4.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO. The result is computed at the start edge and
// held in pending registers, then committed after a fixed busy period.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {StIdle, StRun} state_t;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pend_hi, w_pend_hi_nxt;
  logic [31:0] r_pend_lo, w_pend_lo_nxt;
  logic        r_commit, w_commit_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_a_mag, w_b_mag, w_sdiv_b, w_udiv_b;
  logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
  logic        w_div_zero;

  // Low 64 bits of a product are the same for signed and unsigned once operands are extended.
  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_div_zero = (rt_val == 32'd0);
  assign w_a_mag    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign w_b_mag    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign w_sdiv_b   = w_div_zero ? 32'd1 : w_b_mag;
  assign w_udiv_b   = w_div_zero ? 32'd1 : rt_val;
  assign w_sq_mag   = w_a_mag / w_sdiv_b;
  assign w_sr_mag   = w_a_mag % w_sdiv_b;
  assign w_sq       = (rs_val[31] ^ rt_val[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr       = rs_val[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
  assign w_uq       = rs_val / w_udiv_b;
  assign w_ur       = rs_val % w_udiv_b;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_commit_nxt  = r_commit;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          case (mdu_op)
            OpMult, OpMultu: begin
              w_pend_hi_nxt = (mdu_op == OpMult) ? w_prod_s[63:32] : w_prod_u[63:32];
              w_pend_lo_nxt = (mdu_op == OpMult) ? w_prod_s[31:0]  : w_prod_u[31:0];
              w_commit_nxt  = 1'b1;
              w_cnt_nxt     = 4'(MULT_CYCLES);
              w_state_nxt   = StRun;
            end
            OpDiv, OpDivu: begin
              // A zero divisor still runs the full period but leaves HI/LO untouched.
              if (!w_div_zero) begin
                w_pend_hi_nxt = (mdu_op == OpDiv) ? w_sr : w_ur;
                w_pend_lo_nxt = (mdu_op == OpDiv) ? w_sq : w_uq;
              end
              w_commit_nxt = !w_div_zero;
              w_cnt_nxt    = 4'(DIV_CYCLES);
              w_state_nxt  = StRun;
            end
            OpMthi:  w_hi_nxt = rs_val;
            OpMtlo:  w_lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      StRun: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = StIdle;
          if (r_commit) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_commit  <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_commit  <= w_commit_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign busy = (r_state == StRun);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed vector table, hand-written multi-cycle sequences, and random ops
// checked against an arithmetic reference model of HI/LO.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: HI/LO effect of one op from plain 64-bit arithmetic; returns busy length.
  function automatic int model_apply(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    case (op)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; return 5; end
      3'd1: begin p = 64'(ua * ub); m_hi = p[63:32]; m_lo = p[31:0]; return 5; end
      3'd2: begin
        if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
        return 10;
      end
      3'd3: begin
        if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
        return 10;
      end
      3'd4: begin m_hi = a; return 0; end
      3'd5: begin m_lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Issue one op, scramble operands afterwards, and count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[$];
  int   cyc, exp_cyc, total;

  initial begin
    reset = 1'b0; start = 1'b0; mdu_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;

    vecs.push_back('{"mult_neg3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5});
    vecs.push_back('{"multu_max_x2", 3'd1, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5});
    vecs.push_back('{"div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"mthi_1234", 3'd4, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFD, 0});
    vecs.push_back('{"mtlo_5678", 3'd5, 32'h5678, 32'd0, 32'h1234, 32'h5678, 0});
    vecs.push_back('{"divu_by_zero", 3'd3, 32'd7, 32'd0, 32'h1234, 32'h5678, 10});
    vecs.push_back('{"div_by_zero", 3'd2, 32'hFFFF0000, 32'd0, 32'h1234, 32'h5678, 10});
    vecs.push_back('{"div_overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10});
    vecs.push_back('{"noop_110", 3'd6, 32'h11111111, 32'h2, 32'h0, 32'h80000000, 0});
    vecs.push_back('{"noop_111", 3'd7, 32'h22222222, 32'h3, 32'h0, 32'h80000000, 0});
    vecs.push_back('{"divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10});
    vecs.push_back('{"div_7_neg2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10});
    vecs.push_back('{"mult_maxpos_sq", 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF,
                     32'h00000001, 5});
    vecs.push_back('{"mthi_deadbeef", 3'd4, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'h1, 0});

    // Reset state
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_hi", hi, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Directed table (the last row depends on an mtlo 1 issued just before it)
    foreach (vecs[i]) begin
      if (vecs[i].name == "mthi_deadbeef") begin
        run_op(3'd5, 32'd1, 32'd0, cyc);
        void'(model_apply(3'd5, 32'd1, 32'd0));
      end
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
      void'(model_apply(vecs[i].op, vecs[i].rs, vecs[i].rt));
      check({vecs[i].name, "_cyc"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // Back-to-back mtlo 1 then mult 2x2
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd5; rs_val = 32'd1;
    @(negedge clk);
    check("b2b_mtlo_lo", lo, 32'd1);
    check("b2b_mtlo_busy", {31'd0, busy}, 32'd0);
    mdu_op = 3'd0; rs_val = 32'd2; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_mult_busy", {31'd0, busy}, 32'd1);
    check("b2b_lo_held", lo, 32'd1);
    cyc = 1;
    while (busy && cyc < 40) begin @(negedge clk); if (busy) cyc++; end
    check("b2b_mult_cyc", 32'(cyc), 32'd5);
    check("b2b_mult_lo", lo, 32'd4);
    m_hi = 32'd0; m_lo = 32'd4;

    // Starts during busy are ignored, including mtlo
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd0; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; total = 1;
    @(negedge clk);
    total++;
    start = 1'b1; mdu_op = 3'd5; rs_val = 32'hAAAA;
    @(negedge clk);
    if (busy) total++;
    mdu_op = 3'd0; rs_val = 32'd100; rt_val = 32'd100;
    @(negedge clk);
    if (busy) total++;
    start = 1'b0;
    while (busy && total < 40) begin @(negedge clk); if (busy) total++; end
    check("ignore_cyc", 32'(total), 32'd5);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd42);
    @(negedge clk);
    check("ignore_no_restart", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd42;

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd2; rs_val = 32'd100; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_areset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_hi", hi, 32'd0);
    check("areset_lo", lo, 32'd42 & 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(3'd0, 32'd3, 32'd3, cyc);
    void'(model_apply(3'd0, 32'd3, 32'd3));
    check("after_reset_cyc", 32'(cyc), 32'd5);
    check("after_reset_lo", lo, 32'd9);
    check("after_reset_hi", hi, 32'd0);

    // Random ops against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp_cyc = model_apply(op, a, b);
      run_op(op, a, b, cyc);
      check($sformatf("rand%0d_op%0d_cyc", k, op), 32'(cyc), 32'(exp_cyc));
      check($sformatf("rand%0d_op%0d_hi", k, op), hi, m_hi);
      check($sformatf("rand%0d_op%0d_lo", k, op), lo, m_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
